// File: rtl/key_scan.sv
// key_scan: synchronised, debounced user keys with level plus
// press / release / long-press / auto-repeat event pulses.
module key_scan #(
  parameter int CLK_FREQ_HZ = 24_000_000,
  parameter int NUM_KEYS    = 2,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                tick_1ms
);

  localparam int PRE_TC = CLK_FREQ_HZ / 1000 - 1;
  localparam int PW = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
  localparam int DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int HW = (LONG_MS > 1) ? $clog2(LONG_MS) : 1;
  localparam int RW = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;
  localparam int RP_TC = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;
  localparam bit REP_EN = (REPEAT_MS > 0);

  localparam logic [PW-1:0] PRE_MAX  = PW'(PRE_TC);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(RP_TC);

  localparam logic [NUM_KEYS-1:0] IDLE_PIN =
    {NUM_KEYS{ACTIVE_LOW}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_LONG,
    S_REL_DB
  } state_t;

  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic          r_tick;

  assign w_pre_nxt = (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;

  // tick is registered so it lines up with the terminal count
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= w_pre_nxt;
      r_tick <= (w_pre_nxt == PRE_MAX);
    end
  end

  assign tick_1ms = r_tick;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_act;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= IDLE_PIN;
      r_sync2 <= IDLE_PIN;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_act = r_sync2 ^ IDLE_PIN;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    state_t        r_state;
    logic [DW-1:0] r_db;
    logic [HW-1:0] r_hold;
    logic [RW-1:0] r_rep;
    logic          r_from_long;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          r_repeat;

    // an act change on a tick edge wins: no count, no pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_state     <= S_IDLE;
        r_db        <= '0;
        r_hold      <= '0;
        r_rep       <= '0;
        r_from_long <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
        unique case (r_state)
          S_IDLE: begin
            if (w_act[g]) begin
              r_state <= S_PRESS_DB;
              r_db    <= '0;
            end
          end
          S_PRESS_DB: begin
            if (!w_act[g]) begin
              r_state <= S_IDLE;
            end else if (r_tick) begin
              if (r_db == DB_MAX) begin
                r_state <= S_HELD;
                r_press <= 1'b1;
                r_level <= 1'b1;
                r_hold  <= '0;
              end else begin
                r_db <= r_db + 1'b1;
              end
            end
          end
          S_HELD: begin
            if (!w_act[g]) begin
              r_state     <= S_REL_DB;
              r_db        <= '0;
              r_from_long <= 1'b0;
            end else if (r_tick) begin
              if (r_hold == HOLD_MAX) begin
                r_state <= S_LONG;
                r_long  <= 1'b1;
                r_rep   <= '0;
              end else begin
                r_hold <= r_hold + 1'b1;
              end
            end
          end
          S_LONG: begin
            if (!w_act[g]) begin
              r_state     <= S_REL_DB;
              r_db        <= '0;
              r_from_long <= 1'b1;
            end else if (r_tick && REP_EN) begin
              if (r_rep == REP_MAX) begin
                r_repeat <= 1'b1;
                r_rep    <= '0;
              end else begin
                r_rep <= r_rep + 1'b1;
              end
            end
          end
          S_REL_DB: begin
            if (w_act[g]) begin
              r_state <= r_from_long ? S_LONG : S_HELD;
            end else if (r_tick) begin
              if (r_db == DB_MAX) begin
                r_state   <= S_IDLE;
                r_release <= 1'b1;
                r_level   <= 1'b0;
              end else begin
                r_db <= r_db + 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign key_level[g]   = r_level;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
    assign key_long[g]    = r_long;
    assign key_repeat[g]  = r_repeat;
  end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
Debounced pushbutton input block for the board's user keys; it is the input-side counterpart of the LED output blocks. Each raw key pin is synchronised, debounced on a shared 1 ms tick, and converted into a steady level plus single-cycle press, release, long-press and auto-repeat event pulses. Downstream logic (LED pattern control, mode select) consumes the event pulses directly.

Parameters:
CLK_FREQ_HZ, 24_000_000, sys_clk frequency; prescaler terminal count is CLK_FREQ_HZ/1000-1.
NUM_KEYS, 2, number of independent keys.
ACTIVE_LOW, 1, 1 means a pressed key drives the pin low; 0 means a pressed key drives it high.
DEBOUNCE_MS, 20, stable time in ms required to accept a press or release; must be at least 1.
LONG_MS, 1000, hold time in ms from accepted press to key_long; must be at least 1.
REPEAT_MS, 200, period in ms of key_repeat after key_long; 0 disables repeat.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
key_in  in  NUM_KEYS  raw asynchronous key pins
key_level  out  NUM_KEYS  debounced pressed state, 1 = pressed
key_press  out  NUM_KEYS  1-cycle pulse on accepted press
key_release  out  NUM_KEYS  1-cycle pulse on accepted release
key_long  out  NUM_KEYS  1-cycle pulse when hold time reaches LONG_MS
key_repeat  out  NUM_KEYS  1-cycle pulse every REPEAT_MS after key_long
tick_1ms  out  1  1-cycle strobe every CLK_FREQ_HZ/1000 clocks

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset is asynchronous and active-low on sys_rst_n. All outputs reset to 0.
- Reset state: prescaler = 0, all counters = 0, every key FSM in IDLE, synchroniser flops at the inactive pin level (1 when ACTIVE_LOW=1).
- Prescaler: counts 0..CLK_FREQ_HZ/1000-1 and wraps to 0. tick_1ms is registered and is high for the single cycle in which the count equals the terminal value.
- Synchroniser: 2-flop synchroniser per key. act = synchronised value XOR ACTIVE_LOW. There is no further filtering before the FSM.
- Per-key FSM states: IDLE, PRESS_DB, HELD, LONG, REL_DB. Each key has db_cnt, hold_cnt, rep_cnt, sized to their parameters.
- IDLE: act=1 -> PRESS_DB, db_cnt=0.
- PRESS_DB:
  - act=0 -> IDLE with no pulse; this is bounce rejection.
  - On tick: if db_cnt==DEBOUNCE_MS-1 -> HELD, key_press pulse, key_level=1, hold_cnt=0. Otherwise db_cnt+1.
- HELD:
  - act=0 -> REL_DB, db_cnt=0.
  - On tick: if hold_cnt==LONG_MS-1 -> LONG, key_long pulse, rep_cnt=0. Otherwise hold_cnt+1.
- LONG:
  - act=0 -> REL_DB, db_cnt=0.
  - On tick with REPEAT_MS>0: if rep_cnt==REPEAT_MS-1, emit a key_repeat pulse and set rep_cnt=0. Otherwise rep_cnt+1.
- REL_DB:
  - act=1 -> return to the originating state (HELD or LONG, held in a 1-bit flag) with no pulse. hold_cnt and rep_cnt are frozen during REL_DB and resume from their frozen values.
  - On tick: if db_cnt==DEBOUNCE_MS-1 -> IDLE, key_release pulse, key_level=0. Otherwise db_cnt+1.
- Pulse timing: all event outputs are registered. Each pulse is high for exactly one cycle, starting the cycle after the tick-qualified edge that causes the transition. key_level changes on the same cycle as the matching pulse.
- Press debounce latency: between DEBOUNCE_MS-1 and DEBOUNCE_MS ms after act rises, depending on tick phase, plus 2 cycles for synchronisation.
- Simultaneous events: if an act change and a tick fall on the same edge, the act change wins; no pulse is emitted and the counter is not advanced.
- Independence: keys are fully independent. Any combination of pulses across keys may occur in the same cycle.
- Reset mid-operation: all outputs drop to 0 immediately. A key still held when reset releases must pass the full press debounce again and then emit key_press.
- Counters never exceed their compare values. There is no wrap-around other than the prescaler and rep_cnt.

Test Plan:
All scenarios use CLK_FREQ_HZ=10_000 (tick every 10 clocks), DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, ACTIVE_LOW=1.
1. Bounce rejection: key_in[0] low for 25 clocks, then high for 5, repeated 10 times -> no key_press; key_level[0] stays 0.
2. Clean press: key_in[0] held low for 150 clocks, then high -> exactly one key_press[0] 32..42 clocks after the falling edge, key_level[0]=1. One key_release[0] 32..42 clocks after the rising edge, then key_level[0]=0. No key_long.
3. Long press: key_in[1] held low for 500 clocks -> key_press[1], then key_long[1] exactly 200 clocks after key_press, then key_repeat[1] at +50, +100, +150 ... clocks while held. Exactly one key_release after key_in rises.
4. Release glitch: in HELD, key_in[0] goes high for 20 clocks -> no key_release, key_level stays 1, and key_long is delayed by the 20-clock glitch.
5. Both keys pressed on the same clock -> key_press[0] and key_press[1] on the same cycle; releasing them 3 ticks apart gives independent key_release pulses 3 ticks apart.
6. Reset: assert sys_rst_n=0 in LONG while key_in[0] is held low -> all outputs 0 at once. After release with the key still held, one key_press 32..42 clocks later and no key_release.
